uart_mike_link_ctrl: RTL
========================

// Module: uart_mike_link_ctrl
// PURPOSE
//  Parametrised UART frame controller: next generation of the TX/RX sequencing FSM.
//  Generates per-bit timing for one TX and one RX frame engine.
//  Supports configurable data width, parity and stop bits, and half- or full-duplex
//  arbitration. Detects false starts, framing errors and RX overrun.
//  Sits between the line-side start detector/sampler and the TX/RX shift datapath.
// PARAMETERS
//  DATA_W        8   data bits per frame (5..9)
//  CLKS_PER_BIT  16  clk cycles per bit (>=4, even)
//  STOP_BITS     1   stop bits (1 or 2)
//  PARITY_EN     0   1: one parity bit follows the data bits
//  FULL_DUPLEX   0   0: TX and RX are mutually exclusive; 1: independent
// PORTS
//  clk           in   1        clock
//  rst           in   1        asynchronous, active-high reset
//  tx_send       in   1        level TX request; consumed when TX leaves TX_IDLE
//  tx_busy       out  1        TX frame in progress
//  tx_shift      out  1        1-cycle pulse on the last cycle of each TX bit period
//  tx_phase      out  2        uart_phase_t: START/DATA/PARITY/STOP (valid while tx_busy)
//  tx_bit_idx    out  $clog2(DATA_W)  current TX data bit index
//  tx_done       out  1        1-cycle pulse on the last cycle of the frame
//  rx_start      in   1        1-cycle start-edge pulse from the line detector
//  rx_line       in   1        synchronised RX line level
//  rx_busy       out  1        RX frame in progress
//  rx_sample     out  1        1-cycle mid-bit sample strobe
//  rx_phase      out  2        uart_phase_t of the current RX bit
//  rx_bit_idx    out  $clog2(DATA_W)  current RX data bit index
//  rx_done       out  1        1-cycle pulse: frame received
//  rx_frame_err  out  1        qualifies rx_done: final stop bit sampled 0
//  rx_flag       out  1        data-valid level; set by rx_done, cleared by rx_flag_clr
//  rx_flag_clr   in   1        consumer acknowledge
//  rx_overrun    out  1        sticky; cleared by rx_flag_clr
// BEHAVIOUR
//  Reset: async. Both FSMs return to IDLE; every output and counter reads 0 while rst is high.
//   This holds mid-frame: no done pulse is emitted.
//  TX FSM: TX_IDLE -> TX_START -> TX_DATA(xDATA_W) -> [TX_PAR] -> TX_STOP(xSTOP_BITS) -> TX_IDLE.
//   - tx_send sampled in TX_IDLE; tx_busy=1 from the next cycle.
//   - Frame = (1+DATA_W+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
//   - tx_shift fires on the last cycle of every bit; tx_done coincides with the final tx_shift.
//   - tx_send high during tx_done -> the next frame starts on the next cycle (no gap, busy stays 1).
//  RX FSM: RX_IDLE -> RX_START -> RX_DATA(xDATA_W) -> [RX_PAR] -> RX_STOP(xSTOP_BITS) -> RX_IDLE.
//   - rx_start accepted only in RX_IDLE.
//   - rx_sample fires at cycle CLKS_PER_BIT/2-1 of each bit, counted from the cycle after rx_start.
//   - False start: rx_line=1 at the START sample -> RX_IDLE next cycle, no rx_done.
//   - rx_done (and rx_frame_err if rx_line=0) fires on the sample of the last stop bit;
//     RX_IDLE follows the next cycle (half-bit early for resync).
//  Flag/overrun:
//   - rx_done with rx_flag=1 and no rx_flag_clr -> rx_overrun<=1; the new frame is still reported.
//   - rx_done and rx_flag_clr in the same cycle -> rx_flag=1, rx_overrun=0.
//   - rx_flag_clr alone -> rx_flag=0, rx_overrun=0.
//   - The RX FSM never blocks on rx_flag.
//  FULL_DUPLEX=0:
//   - TX leaves TX_IDLE only if RX is idle and rx_start=0.
//   - Simultaneous rx_start & tx_send in idle -> RX wins; tx_send remains pending.
//   - rx_start while tx_busy is ignored.
//  FULL_DUPLEX=1: the engines are fully independent.
//  Counters:
//   - Cycle counters wrap to 0 at CLKS_PER_BIT-1.
//   - Bit counters wrap to 0 after DATA_W-1 and on every phase change.
// STRUCTURE
//  UART_MIKE_pkg additions: uart_phase_t, uart_tx_state_t, uart_rx_state_t,
//   elaboration checks on parameter ranges.
//  Sub-module uart_mike_tick_counter #(WIDTH,GOAL): en, clr, count, hit.
//   Instantiated 4x: TX cycle, TX bit, RX cycle, RX bit.
// TESTING (DATA_W=8, CLKS_PER_BIT=16, STOP_BITS=1, PARITY_EN=0 unless stated)
//  1. tx_send pulse -> tx_busy 160 cycles; 10 tx_shift; tx_done at cycle 160; bit_idx 0..7.
//  2. tx_send held for 2 frames -> tx_done at 160 and 320; tx_busy never drops between them.
//  3. rx_start, rx_line=0 for 9 bits then 1 -> rx_sample at 7,23,...,151; rx_done at 151;
//     rx_flag=1, no err.
//  4. rx_line=1 at the first sample (cycle 7) -> false start; rx_busy=0 at cycle 8; no rx_done.
//  5. Two frames, no rx_flag_clr -> rx_overrun=1 after the 2nd; rx_flag_clr clears both;
//     clr together with rx_done -> flag 1, overrun 0.
//  6. FULL_DUPLEX=0: tx_send & rx_start same cycle -> RX runs, TX starts the cycle after RX
//     idles. rst high mid-TX -> all outputs 0 immediately. PARITY_EN=1, STOP_BITS=2 -> 192-cycle frame.

Source files
------------

// File: rtl/uart_mike_link_ctrl_pkg.sv
// Shared types and helpers for the UART frame controller.
// Phase encoding, FSM state types and parameter range check.
package uart_mike_link_ctrl_pkg;

  typedef enum logic [1:0] {
    PH_START = 2'd0,
    PH_DATA  = 2'd1,
    PH_PAR   = 2'd2,
    PH_STOP  = 2'd3
  } uart_phase_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } uart_tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } uart_rx_state_t;

  function automatic bit uart_cfg_ok(
    input int data_w,
    input int cpb,
    input int stop_bits,
    input int parity_en,
    input int full_duplex
  );
    return (data_w >= 5) && (data_w <= 9) &&
           (cpb >= 4) && (cpb % 2 == 0) &&
           (stop_bits == 1 || stop_bits == 2) &&
           (parity_en == 0 || parity_en == 1) &&
           (full_duplex == 0 || full_duplex == 1);
  endfunction

  function automatic uart_phase_t tx_phase_of(
    input uart_tx_state_t s
  );
    unique case (s)
      TX_DATA: return PH_DATA;
      TX_PAR:  return PH_PAR;
      TX_STOP: return PH_STOP;
      default: return PH_START;
    endcase
  endfunction

  function automatic uart_phase_t rx_phase_of(
    input uart_rx_state_t s
  );
    unique case (s)
      RX_DATA: return PH_DATA;
      RX_PAR:  return PH_PAR;
      RX_STOP: return PH_STOP;
      default: return PH_START;
    endcase
  endfunction

endpackage

// File: rtl/uart_mike_link_ctrl_tick_counter.sv
// Wrapping up-counter: counts on en, wraps to 0 after GOAL.
// clr has priority and forces the count back to 0.
module uart_mike_tick_counter #(
  parameter int WIDTH = 4,
  parameter int GOAL  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             hit
);

  assign hit = (count == WIDTH'(GOAL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= hit ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_mike_link_ctrl.sv
// UART TX/RX frame sequencer: per-bit timing, false start,
// framing error, data flag and overrun, duplex arbitration.
module uart_mike_link_ctrl
  import uart_mike_link_ctrl_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int FULL_DUPLEX  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_send,
  output logic                      tx_busy,
  output logic                      tx_shift,
  output logic [1:0]                tx_phase,
  output logic [$clog2(DATA_W)-1:0] tx_bit_idx,
  output logic                      tx_done,
  input  logic                      rx_start,
  input  logic                      rx_line,
  output logic                      rx_busy,
  output logic                      rx_sample,
  output logic [1:0]                rx_phase,
  output logic [$clog2(DATA_W)-1:0] rx_bit_idx,
  output logic                      rx_done,
  output logic                      rx_frame_err,
  output logic                      rx_flag,
  input  logic                      rx_flag_clr,
  output logic                      rx_overrun
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BW  = $clog2(DATA_W);
  localparam int MID = CLKS_PER_BIT / 2 - 1;

  if (!uart_cfg_ok(DATA_W, CLKS_PER_BIT, STOP_BITS,
                   PARITY_EN, FULL_DUPLEX)) begin : g_bad_cfg
    $error("uart_mike_link_ctrl: parameter out of range");
  end

  uart_tx_state_t tx_state, tx_next;
  uart_rx_state_t rx_state, rx_next;

  logic [CW-1:0] tx_cyc, rx_cyc;
  logic [BW-1:0] tx_bit, rx_bit;
  logic          tx_cyc_hit, rx_cyc_hit;
  logic          tx_bit_hit, rx_bit_hit;
  logic          tx_chg, rx_chg;
  logic          tx_go, rx_go;
  logic          tx_stop_last, rx_stop_last;
  logic          rx_mid;

  assign tx_busy = (tx_state != TX_IDLE);
  assign rx_busy = (rx_state != RX_IDLE);
  assign tx_chg  = (tx_next != tx_state);
  assign rx_chg  = (rx_next != rx_state);

  // Half duplex: RX wins a same-cycle race, TX waits for RX idle.
  assign tx_go = tx_send &&
    ((FULL_DUPLEX != 0) || (rx_state == RX_IDLE && !rx_start));
  assign rx_go = rx_start &&
    ((FULL_DUPLEX != 0) || (tx_state == TX_IDLE));

  assign tx_stop_last = (tx_bit == BW'(STOP_BITS - 1));
  assign rx_stop_last = (rx_bit == BW'(STOP_BITS - 1));
  assign rx_mid       = (rx_cyc == CW'(MID));

  uart_mike_tick_counter #(
    .WIDTH(CW), .GOAL(CLKS_PER_BIT - 1)
  ) u_tx_cyc (
    .clk(clk), .rst(rst), .en(tx_busy), .clr(tx_chg),
    .count(tx_cyc), .hit(tx_cyc_hit)
  );

  uart_mike_tick_counter #(
    .WIDTH(BW), .GOAL(DATA_W - 1)
  ) u_tx_bit (
    .clk(clk), .rst(rst), .en(tx_busy && tx_cyc_hit),
    .clr(tx_chg), .count(tx_bit), .hit(tx_bit_hit)
  );

  uart_mike_tick_counter #(
    .WIDTH(CW), .GOAL(CLKS_PER_BIT - 1)
  ) u_rx_cyc (
    .clk(clk), .rst(rst), .en(rx_busy), .clr(rx_chg),
    .count(rx_cyc), .hit(rx_cyc_hit)
  );

  uart_mike_tick_counter #(
    .WIDTH(BW), .GOAL(DATA_W - 1)
  ) u_rx_bit (
    .clk(clk), .rst(rst), .en(rx_busy && rx_cyc_hit),
    .clr(rx_chg), .count(rx_bit), .hit(rx_bit_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_IDLE;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
    end
  end

  always_comb begin
    tx_next = tx_state;
    tx_done = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (tx_go) tx_next = TX_START;
      end
      TX_START: begin
        if (tx_cyc_hit) tx_next = TX_DATA;
      end
      TX_DATA: begin
        if (tx_cyc_hit && tx_bit_hit) begin
          if (PARITY_EN != 0) tx_next = TX_PAR;
          else                tx_next = TX_STOP;
        end
      end
      TX_PAR: begin
        if (tx_cyc_hit) tx_next = TX_STOP;
      end
      TX_STOP: begin
        if (tx_cyc_hit && tx_stop_last) begin
          tx_done = 1'b1;
          if (tx_send) tx_next = TX_START;
          else         tx_next = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // Done fires at the last stop-bit sample, half a bit early.
  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_go) rx_next = RX_START;
      end
      RX_START: begin
        if (rx_mid && rx_line) rx_next = RX_IDLE;
        else if (rx_cyc_hit)   rx_next = RX_DATA;
      end
      RX_DATA: begin
        if (rx_cyc_hit && rx_bit_hit) begin
          if (PARITY_EN != 0) rx_next = RX_PAR;
          else                rx_next = RX_STOP;
        end
      end
      RX_PAR: begin
        if (rx_cyc_hit) rx_next = RX_STOP;
      end
      RX_STOP: begin
        if (rx_mid && rx_stop_last) begin
          rx_done = 1'b1;
          rx_next = RX_IDLE;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  assign tx_shift     = tx_busy && tx_cyc_hit;
  assign tx_phase     = tx_phase_of(tx_state);
  assign tx_bit_idx   = tx_bit;
  assign rx_sample    = rx_busy && rx_mid;
  assign rx_phase     = rx_phase_of(rx_state);
  assign rx_bit_idx   = rx_bit;
  assign rx_frame_err = rx_done && !rx_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_flag    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_done)          rx_flag <= 1'b1;
      else if (rx_flag_clr) rx_flag <= 1'b0;
      if (rx_flag_clr)
        rx_overrun <= 1'b0;
      else if (rx_done && rx_flag)
        rx_overrun <= 1'b1;
    end
  end

endmodule
